// File: rtl/fp_pkg.sv
// Shared FP divide/sqrt types.
// The op encoding is common to the mantissa and exponent stages.
package fp_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_SQRT = 2'b01
    } fp_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } divsqrt_state_t;

endpackage

// File: rtl/mantissa_divsqrt_iter_trial_subtract.sv
// Restoring trial subtraction shared by divide and sqrt steps.
// Combinational only.
module trial_subtract #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ge,
    output logic [W-1:0] diff
);

    assign ge   = (a >= b);
    assign diff = ge ? (a - b) : a;

endmodule

// File: rtl/mantissa_divsqrt_iter.sv
// Radix-2 restoring mantissa divider / square-rooter.
// One result bit per cycle; feeds the exponent stage.
module mantissa_divsqrt_iter
    import fp_pkg::*;
#(
    parameter int MW = 23
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [MW:0]     m1,
    input  logic [MW:0]     m2,
    input  logic            odd_exp,
    output logic            busy,
    output logic            done,
    output logic [MW+2:0]   q,
    output logic            sticky,
    output logic            decrement
);

    localparam int QW = MW + 3;
    localparam int RW = QW + 3;
    localparam int XW = 2 * QW;
    localparam int CW = $clog2(QW);

    divsqrt_state_t state;
    logic [1:0]     op_q;
    logic [CW-1:0]  cnt;
    logic [RW-1:0]  r;
    logic [RW-1:0]  r_nxt;
    logic [MW:0]    d;
    logic [XW-1:0]  x;
    logic [RW-1:0]  ts_a;
    logic [RW-1:0]  ts_b;
    logic [RW-1:0]  ts_diff;
    logic           ts_ge;
    logic           is_div;
    logic           is_sqrt;

    // r doubles as divide remainder and sqrt remainder; q doubles as root.
    always_comb begin
        is_div  = (op_q == OP_DIV);
        is_sqrt = (op_q == OP_SQRT);
        ts_a    = is_div ? r : {r[RW-3:0], x[XW-1 -: 2]};
        ts_b    = is_div ? RW'(d) : RW'({q, 2'b01});
        r_nxt   = r;
        if (is_div) begin
            r_nxt = {ts_diff[RW-2:0], 1'b0};
        end else if (is_sqrt) begin
            r_nxt = ts_diff;
        end
    end

    trial_subtract #(
        .W (RW)
    ) u_ts (
        .a    (ts_a),
        .b    (ts_b),
        .ge   (ts_ge),
        .diff (ts_diff)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= '0;
            cnt       <= '0;
            r         <= '0;
            d         <= '0;
            x         <= '0;
            q         <= '0;
            sticky    <= 1'b0;
            decrement <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        cnt       <= CW'(QW - 1);
                        q         <= '0;
                        sticky    <= 1'b0;
                        busy      <= 1'b1;
                        d         <= m2;
                        state     <= ITER;
                        unique case (1'b1)
                            (op == OP_DIV): begin
                                decrement <= (m1 < m2);
                                r <= (m1 < m2) ? RW'({m1, 1'b0})
                                               : RW'(m1);
                                x <= '0;
                            end
                            (op == OP_SQRT): begin
                                decrement <= 1'b0;
                                r <= '0;
                                // radicand has two integer bits
                                x <= odd_exp
                                    ? {m1, 1'b0, {(XW-MW-2){1'b0}}}
                                    : {1'b0, m1, {(XW-MW-2){1'b0}}};
                            end
                            default: begin
                                decrement <= 1'b0;
                                r <= '0;
                                x <= '0;
                            end
                        endcase
                    end
                end
                ITER: begin
                    r <= r_nxt;
                    x <= {x[XW-3:0], 2'b00};
                    if (is_div || is_sqrt) begin
                        q <= {q[QW-2:0], ts_ge};
                    end
                    if (cnt == '0) begin
                        sticky <= |r_nxt;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mantissa_divsqrt_iter.sv
// Bench for mantissa_divsqrt_iter: directed table, random ops vs
// an arithmetic model, and handshake/reset sequences.
module tb_mantissa_divsqrt_iter;

    localparam int MW = 23;
    localparam int QW = MW + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [MW:0]   m1 = '0;
    logic [MW:0]   m2 = '0;
    logic          odd_exp = 1'b0;
    logic          busy;
    logic          done;
    logic [QW-1:0] q;
    logic          sticky;
    logic          decrement;

    int checks = 0;
    int errors = 0;

    mantissa_divsqrt_iter #(
        .MW (MW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .m1        (m1),
        .m2        (m2),
        .odd_exp   (odd_exp),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .sticky    (sticky),
        .decrement (decrement)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [1:0]    op;
        logic [MW:0]   m1;
        logic [MW:0]   m2;
        logic          odd;
        logic [QW-1:0] q;
        logic          st;
        logic          dec;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic longint unsigned isqrt(input longint unsigned n);
        longint unsigned lo = 0;
        longint unsigned hi = 64'd1 << QW;
        longint unsigned mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    // q = floor(true result * 2^(QW-1)); sticky = result inexact
    task automatic model(input logic [1:0] o, input logic [MW:0] a,
                         input logic [MW:0] b, input logic odd,
                         output logic [QW-1:0] eq, output logic es,
                         output logic ed);
        longint unsigned n, qq, s;
        eq = '0;
        es = 1'b0;
        ed = 1'b0;
        if (o == 2'b00) begin
            ed = (a < b);
            n  = 64'(a);
            if (ed) n = n * 2;
            n  = n << (QW - 1);
            qq = n / 64'(b);
            eq = qq[QW-1:0];
            es = (n % 64'(b)) != 0;
        end else if (o == 2'b01) begin
            n  = 64'(a);
            if (odd) n = n * 2;
            n  = n << (2 * (QW - 1) - MW);
            s  = isqrt(n);
            eq = s[QW-1:0];
            es = (s * s) != n;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [MW:0] a,
                          input logic [MW:0] b, input logic odd,
                          output logic [QW-1:0] rq, output logic rs,
                          output logic rd, output int lat);
        op = o;
        m1 = a;
        m2 = b;
        odd_exp = odd;
        start = 1'b1;
        cyc();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            cyc();
            lat++;
        end
        rq = q;
        rs = sticky;
        rd = decrement;
        cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [QW-1:0] rq, eq;
        logic rs, rd, es, ed;
        logic [1:0] ro;
        logic [MW:0] ra, rb;
        logic rodd;
        int lat, ndone;

        vecs[0] = '{"div_1p5", 2'b00, 24'hC00000, 24'h800000, 1'b0,
                    26'h3000000, 1'b0, 1'b0};
        vecs[1] = '{"div_dec", 2'b00, 24'h800000, 24'hC00000, 1'b0,
                    26'h2AAAAAA, 1'b1, 1'b1};
        vecs[2] = '{"sqrt_1", 2'b01, 24'h800000, 24'h000000, 1'b0,
                    26'h2000000, 1'b0, 1'b0};
        vecs[3] = '{"sqrt_2", 2'b01, 24'h800000, 24'h000000, 1'b1,
                    26'h2D413CC, 1'b1, 1'b0};
        vecs[4] = '{"div_max", 2'b00, 24'hFFFFFF, 24'h800000, 1'b0,
                    26'h3FFFFFC, 1'b0, 1'b0};
        vecs[5] = '{"div_min", 2'b00, 24'h800000, 24'hFFFFFF, 1'b0,
                    26'h2000002, 1'b1, 1'b1};
        vecs[6] = '{"div_eq", 2'b00, 24'hABCDEF, 24'hABCDEF, 1'b0,
                    26'h2000000, 1'b0, 1'b0};
        vecs[7] = '{"rsvd", 2'b11, 24'hC00000, 24'h900000, 1'b1,
                    26'h0000000, 1'b0, 1'b0};

        cyc();
        cyc();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_q", 64'(q), 64'd0);
        chk("rst_sticky", 64'(sticky), 64'd0);
        chk("rst_dec", 64'(decrement), 64'd0);
        reset = 1'b0;
        cyc();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].m1, vecs[i].m2, vecs[i].odd,
                   rq, rs, rd, lat);
            chk({vecs[i].name, "_q"}, 64'(rq), 64'(vecs[i].q));
            chk({vecs[i].name, "_st"}, 64'(rs), 64'(vecs[i].st));
            chk({vecs[i].name, "_dec"}, 64'(rd), 64'(vecs[i].dec));
            chk({vecs[i].name, "_lat"}, 64'(lat), 64'(QW + 1));
        end

        for (int i = 0; i < 60; i++) begin
            ro   = ($urandom_range(0, 9) == 0) ? 2'b10
                                               : 2'($urandom_range(0, 1));
            ra   = {1'b1, 23'($urandom)};
            rb   = {1'b1, 23'($urandom)};
            rodd = 1'($urandom);
            model(ro, ra, rb, rodd, eq, es, ed);
            run_op(ro, ra, rb, rodd, rq, rs, rd, lat);
            chk("rnd_q", 64'(rq), 64'(eq));
            chk("rnd_st", 64'(rs), 64'(es));
            chk("rnd_dec", 64'(rd), 64'(ed));
            chk("rnd_lat", 64'(lat), 64'(QW + 1));
        end

        // starts while busy are dropped; start right after done is taken
        op = 2'b00;
        m1 = 24'hC00000;
        m2 = 24'h800000;
        odd_exp = 1'b0;
        start = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 28; c++) begin
            cyc();
            if (c == 1) chk("seq5_busy1", 64'(busy), 64'd1);
            if (done) ndone++;
            if (c == 27) begin
                chk("seq5_done27", 64'(done), 64'd1);
                chk("seq5_q", 64'(q), 64'h3000000);
            end
            start = (c == 5) || (c == 27) || (c == 28);
            if (c == 5) begin
                op = 2'b01;
                m1 = 24'hFFFFFF;
            end
            if (c >= 27) begin
                op = 2'b01;
                m1 = 24'h800000;
                odd_exp = 1'b0;
            end
        end
        cyc();
        start = 1'b0;
        chk("seq5_ndone", 64'(ndone), 64'd1);
        chk("seq5_busy29", 64'(busy), 64'd1);
        lat = 1;
        while (!done && lat < 200) begin
            cyc();
            lat++;
        end
        chk("seq5_lat2", 64'(lat), 64'(QW + 1));
        chk("seq5_q2", 64'(q), 64'h2000000);
        cyc();

        // reset in cycle 10 of a divide
        op = 2'b00;
        m1 = 24'h800000;
        m2 = 24'hC00000;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            start = 1'b0;
            if (c == 1) chk("seq6_qclr", 64'(q), 64'd0);
            if (c == 10) begin
                chk("seq6_dec10", 64'(decrement), 64'd1);
                reset = 1'b1;
            end
        end
        cyc();
        reset = 1'b0;
        chk("seq6_busy", 64'(busy), 64'd0);
        chk("seq6_done", 64'(done), 64'd0);
        chk("seq6_q", 64'(q), 64'd0);
        chk("seq6_dec", 64'(decrement), 64'd0);
        chk("seq6_st", 64'(sticky), 64'd0);
        run_op(2'b00, 24'hC00000, 24'h800000, 1'b0, rq, rs, rd, lat);
        chk("seq6_fresh_q", 64'(rq), 64'h3000000);
        chk("seq6_fresh_lat", 64'(lat), 64'(QW + 1));

        // start together with reset is lost
        reset = 1'b1;
        start = 1'b1;
        cyc();
        reset = 1'b0;
        start = 1'b0;
        cyc();
        chk("rst_start_busy", 64'(busy), 64'd0);
        ndone = 0;
        for (int c = 0; c < QW + 4; c++) begin
            cyc();
            if (done) ndone++;
        end
        chk("rst_start_ndone", 64'(ndone), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
